// File: rtl/led_pattern_ctrl_if.sv
// Board-side pin bundle of the LED pattern controller: raw switches in,
// LED drive plus debounced switch, mode and step-pulse observation out.
interface led_pattern_ctrl_if;
    logic [3:0] swt;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;
    logic [3:0] swt_db;

    modport master (
        output swt,
        input  led,
        input  mode,
        input  tick,
        input  swt_db
    );

    modport slave (
        input  swt,
        output led,
        output mode,
        output tick,
        output swt_db
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Clocked LED pattern engine: synchronizes and debounces four switches, decodes
// mode/speed from them, and steps the LEDs through timed patterns.
module led_pattern_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int TICK_DIV   = 50000
) (
    input  logic clk,
    input  logic rst_n,
    led_pattern_ctrl_if.slave pins
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PW = $clog2(4 * TICK_DIV + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          swt_db_q, swt_db_d;
    logic [3:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
    mode_e               mode_prev_q;
    logic [1:0]          spd_prev_q;
    logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
    logic [3:0]          pat_q, pat_d;
    logic                dir_q, dir_d;   // 0 = moving left, 1 = moving right
    logic [3:0]          led_q, led_d;

    mode_e               mode_cur;
    logic [1:0]          spd;
    logic [PW-1:0]       per_last;
    logic                mode_chg;
    logic                spd_chg;
    logic                step;

    assign mode_cur = mode_e'(swt_db_q[3:2]);
    assign spd      = swt_db_q[1:0];
    assign mode_chg = (mode_cur != mode_prev_q);
    assign spd_chg  = (spd != spd_prev_q);

    always_comb begin
        case (spd)
            2'd0:    per_last = PW'(TICK_DIV - 1);
            2'd1:    per_last = PW'(2 * TICK_DIV - 1);
            2'd2:    per_last = PW'(3 * TICK_DIV - 1);
            default: per_last = PW'(4 * TICK_DIV - 1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            swt_db_q    <= '0;
            deb_cnt_q   <= '0;
            mode_prev_q <= MODE_PASS;
            spd_prev_q  <= '0;
            pre_cnt_q   <= '0;
            pat_q       <= 4'b0001;
            dir_q       <= 1'b0;
            led_q       <= '0;
        end else begin
            sync1_q     <= pins.swt;
            sync2_q     <= sync1_q;
            swt_db_q    <= swt_db_d;
            deb_cnt_q   <= deb_cnt_d;
            mode_prev_q <= mode_cur;
            spd_prev_q  <= spd;
            pre_cnt_q   <= pre_cnt_d;
            pat_q       <= pat_d;
            dir_q       <= dir_d;
            led_q       <= led_d;
        end
    end

    always_comb begin
        swt_db_d  = swt_db_q;
        deb_cnt_d = deb_cnt_q;
        pre_cnt_d = pre_cnt_q;
        step      = 1'b0;
        pat_d     = pat_q;
        dir_d     = dir_q;
        led_d     = led_q;

        for (int b = 0; b < 4; b++) begin
            if (sync2_q[b] == swt_db_q[b]) begin
                deb_cnt_d[b] = '0;
            end else if (deb_cnt_q[b] == DEB_LAST) begin
                swt_db_d[b]  = sync2_q[b];
                deb_cnt_d[b] = '0;
            end else begin
                deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
            end
        end

        // A mode change restarts the step; a speed drop past the count wraps silently.
        if (mode_chg) begin
            pre_cnt_d = '0;
        end else if (spd_chg && (pre_cnt_q >= per_last)) begin
            pre_cnt_d = '0;
        end else if (pre_cnt_q == per_last) begin
            pre_cnt_d = '0;
            step      = 1'b1;
        end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
        end

        if (mode_chg) begin
            dir_d = 1'b0;
            pat_d = (mode_cur == MODE_BLINK) ? 4'b0000 : 4'b0001;
        end else if (step) begin
            case (mode_cur)
                MODE_RUN:   pat_d = {pat_q[2:0], pat_q[3]};
                MODE_BLINK: pat_d = ~pat_q;
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        if (pat_q[3]) begin
                            pat_d = 4'b0100;
                            dir_d = 1'b1;
                        end else begin
                            pat_d = pat_q << 1;
                        end
                    end else begin
                        if (pat_q[0]) begin
                            pat_d = 4'b0010;
                            dir_d = 1'b0;
                        end else begin
                            pat_d = pat_q >> 1;
                        end
                    end
                end
                default: pat_d = pat_q;
            endcase
        end

        // Hold the LEDs through the change cycle so a stale pattern never flashes.
        if (!mode_chg) begin
            led_d = (mode_cur == MODE_PASS) ? swt_db_q : pat_q;
        end
    end

    assign pins.led    = led_q;
    assign pins.mode   = swt_db_q[3:2];
    assign pins.swt_db = swt_db_q;
    assign pins.tick   = step & rst_n;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with DEB_CYCLES=4, TICK_DIV=3: debounce
// vector table followed by hand-timed pattern, mode-change and speed sequences.
module tb_led_pattern_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    led_pattern_ctrl_if pins ();

    led_pattern_ctrl #(
        .DEB_CYCLES (4),
        .TICK_DIV   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] swt;
        int         cyc;
        logic [3:0] exp_db;
        logic [3:0] exp_led;
        logic [1:0] exp_mode;
    } vec_t;

    vec_t       vecs[9];
    logic [3:0] run_exp[4];
    logic [3:0] bounce_exp[7];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic next_tick(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!pins.tick && n < 100);
        check("tick_seen", {31'd0, pins.tick}, 32'd1);
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;

        vecs[0] = '{4'b0010, 5, 4'b0000, 4'b0000, 2'b00};
        vecs[1] = '{4'b0010, 1, 4'b0010, 4'b0000, 2'b00};
        vecs[2] = '{4'b0010, 1, 4'b0010, 4'b0010, 2'b00};
        vecs[3] = '{4'b0011, 2, 4'b0010, 4'b0010, 2'b00};
        vecs[4] = '{4'b0010, 8, 4'b0010, 4'b0010, 2'b00};
        vecs[5] = '{4'b0001, 6, 4'b0001, 4'b0010, 2'b00};
        vecs[6] = '{4'b0001, 1, 4'b0001, 4'b0001, 2'b00};
        vecs[7] = '{4'b0100, 6, 4'b0100, 4'b0001, 2'b01};
        vecs[8] = '{4'b0100, 2, 4'b0100, 4'b0001, 2'b01};
        run_exp    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

        // Clock/reset
        pins.swt = 4'b0000;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        step(3);
        check("rst_led", pins.led, 4'b0000);
        check("rst_mode", pins.mode, 2'b00);
        check("rst_tick", pins.tick, 1'b0);
        check("rst_swt_db", pins.swt_db, 4'b0000);
        rst_n = 1'b1;

        // Debounce / PASS vector table
        for (int i = 0; i < 9; i++) begin
            pins.swt = vecs[i].swt;
            step(vecs[i].cyc);
            check($sformatf("vec%0d_swt_db", i), pins.swt_db, vecs[i].exp_db);
            check($sformatf("vec%0d_led", i), pins.led, vecs[i].exp_led);
            check($sformatf("vec%0d_mode", i), pins.mode, vecs[i].exp_mode);
        end

        // RUN, spd 0: first step one cycle away, then every 3 clocks
        next_tick(n);
        check("run_first_tick", n, 1);
        for (int i = 0; i < 4; i++) begin
            step(2);
            check($sformatf("run_led%0d", i), pins.led, run_exp[i]);
            next_tick(n);
            check($sformatf("run_period%0d", i), n + 2, 3);
        end

        // BOUNCE, spd 3: period 12
        pins.swt = 4'b1111;
        step(6);
        check("bounce_mode", pins.mode, 2'b11);
        check("bounce_swt_db", pins.swt_db, 4'b1111);
        step(2);
        check("bounce_start_led", pins.led, 4'b0001);
        next_tick(n);
        check("bounce_first_tick", n + 8, 18);
        for (int i = 0; i < 7; i++) begin
            step(2);
            check($sformatf("bounce_led%0d", i), pins.led, bounce_exp[i]);
            next_tick(n);
            check($sformatf("bounce_period%0d", i), n + 2, 12);
        end

        // BLINK, then switch to RUN so the change lands on a tick slot
        pins.swt = 4'b1000;
        step(6);
        check("blink_mode", pins.mode, 2'b10);
        step(2);
        check("blink_start_led", pins.led, 4'b0000);
        next_tick(n);
        check("blink_first_tick", n, 1);
        step(2);
        check("blink_led0", pins.led, 4'b1111);
        next_tick(n);
        check("blink_period0", n + 2, 3);
        step(2);
        check("blink_led1", pins.led, 4'b0000);
        next_tick(n);
        check("blink_period1", n + 2, 3);
        pins.swt = 4'b0100;
        step(2);
        check("blink_led2", pins.led, 4'b1111);
        step(4);
        check("chg_tick_suppressed", pins.tick, 1'b0);
        check("chg_mode", pins.mode, 2'b01);
        step(2);
        check("chg_led", pins.led, 4'b0001);
        check("chg_no_early_tick", pins.tick, 1'b0);
        step(1);
        check("chg_tick_after3", pins.tick, 1'b1);

        // Speed up to spd 3 keeps counting; speed down with count past the new end wraps silently
        pins.swt = 4'b0111;
        step(6);
        check("spd_up_no_tick", pins.tick, 1'b0);
        check("spd_up_swt_db", pins.swt_db, 4'b0111);
        next_tick(n);
        check("spd_up_tick", n, 9);
        step(3);
        pins.swt = 4'b0100;
        step(6);
        check("spd_dn_swt_db", pins.swt_db, 4'b0100);
        check("spd_dn_no_tick", pins.tick, 1'b0);
        next_tick(n);
        check("spd_dn_tick_after3", n, 3);

        // Asynchronous reset mid-pattern
        check("pre_reset_led_on", {31'd0, (pins.led != 4'b0000)}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_led", pins.led, 4'b0000);
        check("async_rst_tick", pins.tick, 1'b0);
        check("async_rst_mode", pins.mode, 2'b00);
        check("async_rst_swt_db", pins.swt_db, 4'b0000);
        pins.swt = 4'b0000;
        step(3);
        rst_n = 1'b1;
        step(10);
        check("post_rst_led", pins.led, 4'b0000);
        check("post_rst_mode", pins.mode, 2'b00);
        check("post_rst_swt_db", pins.swt_db, 4'b0000);
        next_tick(n);
        next_tick(n);
        check("pass_tick_period", n, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
